// File: rtl/fp_issue_queue.sv
// fp_issue_queue: holds float_alu requests in a small FIFO and issues them to the
// ALU one at a time. Op codes the ALU does not implement are retired here and
// never reach it. Results come back in push order, tagged, from one output register.
//
// Handshakes: every valid/ready pair transfers on the rising edge where both are
// high. A valid stays high with its payload held until that transfer. A ready
// may depend on the opposite side's state, but never on the valid it qualifies.
module fp_issue_queue #(
    parameter int P     = 23,
    parameter int E     = 8,
    parameter int N     = P + E + 1,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [2:0]       in_op,
    input  logic             in_mode_fp,
    input  logic             in_round_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     alu_op_a,
    output logic [N-1:0]     alu_op_b,
    output logic [2:0]       alu_op_code,
    output logic             alu_mode_fp,
    output logic             alu_round_mode,
    output logic             alu_start,
    output logic             alu_ready_in,
    input  logic             alu_valid_out,
    input  logic             alu_ready_out,
    input  logic [N-1:0]     alu_result,
    input  logic [4:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [4:0]       flags_sticky,
    input  logic             flags_clear,
    output logic             dbg_state
);

    // Op codes shared with float_alu
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic [2:0]       op;
        logic             mode_fp;
        logic             round_mode;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    req_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    state_t      state;
    req_t        head;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        head_legal;
    logic        out_free;
    logic        cap_alu;
    logic        cap_ill;
    logic        capture;
    logic [N-1:0] cap_result;
    logic [4:0]  cap_flags;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    // The head stays in the FIFO until capture, so the ALU bus is stable while it works
    assign head           = mem[rd_ptr[AW-1:0]];
    assign head_legal     = (head.op == OP_ADD) || (head.op == OP_SUB) ||
                            (head.op == OP_MUL) || (head.op == OP_DIV);
    assign alu_op_a       = head.a;
    assign alu_op_b       = head.b;
    assign alu_op_code    = head.op;
    assign alu_mode_fp    = head.mode_fp;
    assign alu_round_mode = head.round_mode;

    // alu_start is decoded from state, not registered: a request pushed at edge t
    // must be able to start in cycle t+1
    assign out_free     = !out_valid || out_ready;
    assign alu_ready_in = (state == S_WAIT) && out_free;
    assign alu_start    = (state == S_IDLE) && !empty && head_legal && alu_ready_out;
    assign cap_alu      = (state == S_WAIT) && alu_valid_out && alu_ready_in;
    assign cap_ill      = (state == S_IDLE) && !empty && !head_legal && out_free;
    assign capture      = cap_alu || cap_ill;
    assign pop          = capture;
    assign cap_result   = cap_alu ? alu_result : '0;
    assign cap_flags    = cap_alu ? alu_flags : '0;
    assign dbg_state    = (state == S_WAIT);

    // FIFO storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= req_t'{a: in_a, b: in_b, op: in_op, mode_fp: in_mode_fp,
                                          round_mode: in_round_mode, tag: in_tag};
        end
    end

    // FIFO pointer update; push and pop in the same cycle leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_INC;
            if (pop)  rd_ptr <= rd_ptr + PTR_INC;
        end
    end

    // Sequencer: IDLE issues or retires the head, WAIT holds until the ALU result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (alu_start) state <= S_WAIT;
                S_WAIT:  if (cap_alu) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: a capture overrides a same-cycle drain, so valid stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_result  <= cap_result;
            out_flags   <= cap_flags;
            out_tag     <= head.tag;
            out_illegal <= cap_ill;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end
    end

    // Sticky flags: a clear in a capture cycle keeps only the newly captured flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_sticky <= '0;
        end else if (capture) begin
            flags_sticky <= flags_clear ? cap_flags : (flags_sticky | cap_flags);
        end else if (flags_clear) begin
            flags_sticky <= '0;
        end
    end

endmodule

// File: doc/fp_issue_queue.md
# fp_issue_queue

Request buffer and sequencer directly upstream of `float_alu`. It accepts operation requests on a valid/ready port and buffers them in a small FIFO. Requests go to the ALU one at a time under its start/ready_out/valid_out/ready_in handshake, and each result is returned in order on a registered valid/ready output with a tag. It also keeps sticky exception flags and retires illegal op codes locally, so the ALU never sees them.

## Interface
- `P`, 23, mantissa width (matches `float_alu`)
- `E`, 8, exponent width
- `N`, P+E+1, operand/result width
- `DEPTH`, 4, request FIFO entries (power of two, ≥2)
- `TAG_W`, 4, request tag width
- `clk` in 1: the single clock; everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1: request handshake.
- `in_a`, `in_b` in N: operands.
- `in_op` in 3: `OP_*` code from macros.vh.
- `in_mode_fp`, `in_round_mode` in 1: passed through to the ALU.
- `in_tag` in TAG_W: returned with the result.
- `alu_op_a`, `alu_op_b` out N; `alu_op_code` out 3; `alu_mode_fp`, `alu_round_mode` out 1: ALU operand bus.
- `alu_start` out 1, `alu_ready_in` out 1: to the ALU.
- `alu_valid_out` in 1, `alu_ready_out` in 1, `alu_result` in N, `alu_flags` in 5: from the ALU.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_result` out N, `out_flags` out 5, `out_tag` out TAG_W, `out_illegal` out 1: result payload.
- `flags_sticky` out 5: OR of all retired flags. `flags_clear` in 1: synchronous clear.

## Operation
- **FIFO**
  - Push when `in_valid && in_ready`; `in_ready = !full`.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full means the MSBs differ and the lower bits are equal.
  - The head entry stays in the FIFO until it retires, i.e. is captured into the output register.
- **Legal ops**: `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`. Any other code is illegal.
- **ALU bus**: `alu_*` operand fields are driven combinationally from the FIFO head. They are stable for the whole operation because the head is not popped until capture.
- **Output free**: `out_free = !out_valid || out_ready`. `alu_ready_in = out_free` in S_WAIT and 1'b0 otherwise.
- **FSM, S_IDLE**
  - Head legal and `alu_ready_out`: assert `alu_start` for exactly this cycle, then go to S_WAIT.
  - Head illegal and `out_free`: capture result 0, flags 0, `out_illegal` = 1; pop; stay in S_IDLE. `alu_start` stays low.
  - FIFO empty: stay in S_IDLE.
- **FSM, S_WAIT**
  - On `alu_valid_out && alu_ready_in`: capture `alu_result`, `alu_flags` and the head tag, with `out_illegal` = 0. Pop and go to S_IDLE.
  - Otherwise hold. `alu_start` = 0.
- **Capture**
  - Loads the output register and sets `out_valid`.
  - The output register clears when `out_ready && out_valid` and no capture happens that cycle. Capture and drain in the same cycle is allowed: new data replaces old and `out_valid` stays 1.
- **Sticky flags**: on capture, `flags_sticky` becomes `flags_sticky | captured_flags`. If `flags_clear` is asserted in the same cycle, `flags_sticky` becomes `captured_flags` only. `flags_clear` alone zeroes it.
- **Simultaneous push and pop** in one cycle is legal, and the count is unchanged. Push on full is impossible because `in_ready` is low.
- **Ordering**: results leave strictly in push order.

## Timing
- **Reset**:
  - FIFO empty, state S_IDLE.
  - `out_valid`, `out_result`, `out_flags`, `out_tag`, `out_illegal`, `flags_sticky` all 0.
  - `alu_start` 0 and `alu_ready_in` 0.
  - `in_ready` 1 from the first cycle after reset release.
- **Reset mid-operation**: all state is dropped immediately. The ALU shares `rst_n`, so there is no stale completion. In-flight and queued requests are lost.
- **Latency**:
  - Push at edge t into an empty FIFO makes the head visible in cycle t+1. `alu_start` is asserted in cycle t+1 if `alu_ready_out` is high.
  - Capture happens at the edge where `alu_valid_out && alu_ready_in` holds; `out_valid` is high the following cycle.
  - Illegal op: `out_valid` is high 2 cycles after the push edge when the output is free.
- **Throughput**: one op in flight. Back-to-back ops have one S_IDLE cycle between capture and the next `alu_start`.
- **Backpressure**: with `out_ready` held low, one result sits in the output register. The FIFO then fills: DEPTH queued entries, counting the one stalled in S_WAIT.

## Test plan
- Reset release, then push ADD 0x3F800000 + 0x40000000 with tag 1 and `out_ready` = 1 → `alu_start` pulses for one cycle and `out_result` = 0x40400000 with `out_tag` = 1.
- Push MUL 0x40000000×0x40400000 (tag 2), then DIV 0x40C00000/0x40000000 (tag 3), back to back → outputs are 0x40C00000 then 0x40400000, in tag order.
- With `out_ready` = 0, push 6 requests → 5 are accepted (1 in the output register, DEPTH=4 held) and `in_ready` drops. Release `out_ready` → all 5 drain in order with no duplicates.
- Push an undefined op code with tag 7 → `alu_start` never asserts, and the output is 0 with `out_illegal` = 1 and `out_tag` = 7. The following legal op is unaffected.
- Retire an op with nonzero `alu_flags` (e.g. DIV by 0x00000000) → `flags_sticky` holds those flags after a later clean op. Pulse `flags_clear` on a capture cycle → `flags_sticky` equals the captured flags only.
- Assert `rst_n` low while in S_WAIT with 3 entries queued → outputs go to reset values immediately, and after release the FIFO is empty with `in_ready` = 1.
